// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - transfer-size encodings, MMIO offsets and alignment helpers for dmem_unit
package dmem_pkg;

    typedef enum logic [2:0] {
        MT_BYTE  = 3'b000,
        MT_HALF  = 3'b001,
        MT_WORD  = 3'b010,
        MT_BYTEU = 3'b100,
        MT_HALFU = 3'b101
    } mem_type_e;

    localparam logic [3:0] MMIO_CNT_LO = 4'h0;
    localparam logic [3:0] MMIO_CNT_HI = 4'h4;
    localparam logic [3:0] MMIO_LED    = 4'h8;
    localparam logic [3:0] MMIO_STATUS = 4'hC;

    // Legal size code and naturally aligned for that size.
    function automatic logic access_ok(input logic [2:0] mem_type, input logic [1:0] addr_lo);
        case (mem_type)
            MT_BYTE, MT_BYTEU: access_ok = 1'b1;
            MT_HALF, MT_HALFU: access_ok = ~addr_lo[0];
            MT_WORD:           access_ok = (addr_lo == 2'b00);
            default:           access_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [2:0] mem_type);
        case (mem_type)
            MT_BYTE, MT_BYTEU: size_mask = 32'h0000_00FF;
            MT_HALF, MT_HALFU: size_mask = 32'h0000_FFFF;
            MT_WORD:           size_mask = 32'hFFFF_FFFF;
            default:           size_mask = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] size_lanes(input logic [2:0] mem_type);
        case (mem_type)
            MT_BYTE, MT_BYTEU: size_lanes = 4'b0001;
            MT_HALF, MT_HALFU: size_lanes = 4'b0011;
            MT_WORD:           size_lanes = 4'b1111;
            default:           size_lanes = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane placement of store data and extraction of load data
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_type,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [31:0] wr_word,
    output logic [3:0]  byte_en,
    output logic [31:0] rd_data
);

    logic [4:0] shamt;

    assign shamt   = {addr_lo, 3'b000};
    assign wr_word = wr_data << shamt;
    assign byte_en = size_lanes(mem_type) << addr_lo;
    // Loads are zero-extended regardless of the signed/unsigned size code.
    assign rd_data = (rd_word >> shamt) & size_mask(mem_type);

endmodule

// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - zero-wait data memory with misalign fault capture; MMIO window under DMEM_MMIO_EN
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic        misalign_fault,
    output logic [31:0] fault_addr,
    output logic [7:0]  led_out
);

    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_MMIO_EN
    localparam logic MMIO_ON = 1'b1;
`else
    localparam logic MMIO_ON = 1'b0;
`endif

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic          in_ram, in_mmio, legal, fault_now, wr_ok, fault_clr;
    logic [31:0]   wr_word, rd_data, mmio_rd;
    logic [3:0]    byte_en;

    assign widx    = MEM_addr[AW+1:2];
    assign in_ram  = (MEM_addr >> (AW + 2)) == 32'd0;
    assign in_mmio = MMIO_ON & ~in_ram & (MEM_addr[31:4] == MMIO_BASE[31:4]);

    // MMIO registers only accept aligned word accesses.
    assign legal     = in_mmio ? (MEM_type == MT_WORD && MEM_addr[1:0] == 2'b00)
                               : access_ok(MEM_type, MEM_addr[1:0]);
    assign fault_now = (MEM_rd_en | MEM_wr_en) & (in_ram | in_mmio) & ~legal;
    assign wr_ok     = MEM_wr_en & ~Reset & legal;

    dmem_lane_align u_align (
        .addr_lo  (MEM_addr[1:0]),
        .mem_type (MEM_type),
        .wr_data  (MEM_WR_out),
        .rd_word  (ram[widx]),
        .wr_word  (wr_word),
        .byte_en  (byte_en),
        .rd_data  (rd_data)
    );

    always_ff @(posedge CLK) begin
        if (wr_ok && in_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[widx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            misalign_fault <= 1'b0;
            fault_addr     <= 32'd0;
        end else if (fault_clr) begin
            misalign_fault <= 1'b0;
        end else if (fault_now && !misalign_fault) begin
            misalign_fault <= 1'b1;
            fault_addr     <= MEM_addr;
        end
    end

`ifdef DMEM_MMIO_EN
    logic [63:0] cycle_cnt;
    logic [7:0]  led_q;
    logic        mmio_wr;

    assign mmio_wr   = wr_ok & in_mmio;
    assign fault_clr = mmio_wr & (MEM_addr[3:0] == MMIO_STATUS) & MEM_WR_out[0];
    assign led_out   = led_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_cnt <= 64'd0;
            led_q     <= 8'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (mmio_wr && MEM_addr[3:0] == MMIO_LED) led_q <= MEM_WR_out[7:0];
        end
    end

    always_comb begin
        mmio_rd = 32'd0;
        case (MEM_addr[3:0])
            MMIO_CNT_LO: mmio_rd = cycle_cnt[31:0];
            MMIO_CNT_HI: mmio_rd = cycle_cnt[63:32];
            MMIO_LED:    mmio_rd = {24'd0, led_q};
            MMIO_STATUS: mmio_rd = {31'd0, misalign_fault};
            default:     mmio_rd = 32'd0;
        endcase
    end
`else
    assign fault_clr = 1'b0;
    assign led_out   = 8'd0;
    assign mmio_rd   = 32'd0;
`endif

    // A combined read+write performs only the store, so the load path is silenced.
    always_comb begin
        MEM_data = 32'd0;
        if (MEM_rd_en && !MEM_wr_en && legal) begin
            if (in_ram)       MEM_data = rd_data;
            else if (in_mmio) MEM_data = mmio_rd;
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// tb/tb_dmem_unit.sv - scoreboard bench for dmem_unit against a byte-addressed reference model
module tb_dmem_unit;

    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam int          RAM_BYTES = 4096;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] MEM_addr = '0;
    logic [31:0] MEM_WR_out = '0;
    logic [2:0]  MEM_type = 3'b010;
    logic        MEM_rd_en = 1'b0;
    logic        MEM_wr_en = 1'b0;
    logic [31:0] MEM_data;
    logic        misalign_fault;
    logic [31:0] fault_addr;
    logic [7:0]  led_out;

    dmem_unit #(.DEPTH_WORDS(1024), .MMIO_BASE(MMIO_BASE)) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .MEM_addr       (MEM_addr),
        .MEM_WR_out     (MEM_WR_out),
        .MEM_type       (MEM_type),
        .MEM_rd_en      (MEM_rd_en),
        .MEM_wr_en      (MEM_wr_en),
        .MEM_data       (MEM_data),
        .misalign_fault (misalign_fault),
        .fault_addr     (fault_addr),
        .led_out        (led_out)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        bit        chk_state;
        bit [31:0] data;
        bit        fault;
        bit [31:0] faddr;
        bit [7:0]  led;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    byte unsigned    mm[bit [31:0]];
    bit              m_fault = 0;
    bit [31:0]       m_faddr = 0;
    bit [7:0]        m_led = 0;
    longint unsigned m_cnt = 0;
    bit              state_known = 0;

    function automatic int xfer_bytes(input bit [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit is_mmio(input bit [31:0] a);
`ifdef DMEM_MMIO_EN
        return a[31:4] == MMIO_BASE[31:4];
`else
        return 1'b0;
`endif
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endfunction

    task automatic cycle(input bit rst, input bit [31:0] a, input bit [31:0] wd,
                         input bit [2:0] t, input bit rd, input bit wr);
        exp_t     e;
        int       n;
        bit       ram, mmio, legal, flt, clr;
        @(posedge CLK);
        #1;
        Reset = rst; MEM_addr = a; MEM_WR_out = wd; MEM_type = t;
        MEM_rd_en = rd; MEM_wr_en = wr;

        n     = xfer_bytes(t);
        ram   = a < RAM_BYTES;
        mmio  = !ram && is_mmio(a);
        legal = (n != 0) && (a % n == 0) && (!mmio || n == 4);
        flt   = (rd || wr) && (ram || mmio) && !legal;

        e.chk_state = state_known;
        e.fault = m_fault; e.faddr = m_faddr; e.led = m_led;
        e.data = 0;
        if (rd && !wr && legal) begin
            if (ram) begin
                for (int i = 0; i < n; i++) e.data |= 32'(mm[a + i]) << (8 * i);
            end else if (mmio) begin
                case (a[3:0])
                    4'h0: e.data = m_cnt[31:0];
                    4'h4: e.data = m_cnt[63:32];
                    4'h8: e.data = {24'd0, m_led};
                    4'hC: e.data = {31'd0, m_fault};
                    default: e.data = 0;
                endcase
            end
        end
        sb.push_back(e);

        clr = 0;
        if (rst) begin
            m_fault = 0; m_faddr = 0; m_led = 0; m_cnt = 0; state_known = 1;
        end else begin
            m_cnt++;
            if (wr && legal) begin
                if (ram) begin
                    for (int i = 0; i < n; i++) mm[a + i] = 8'(wd >> (8 * i));
                end else if (mmio) begin
                    if (a[3:0] == 4'h8) m_led = wd[7:0];
                    if (a[3:0] == 4'hC && wd[0]) clr = 1;
                end
            end
            if (clr) m_fault = 0;
            else if (flt && !m_fault) begin
                m_fault = 1; m_faddr = a;
            end
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mem_data", MEM_data, e.data);
            if (e.chk_state) begin
                chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, e.fault});
                chk("fault_addr", fault_addr, e.faddr);
                chk("led_out", {24'd0, led_out}, {24'd0, e.led});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] a;
        bit [2:0]  t;
        int        r;

        cycle(1, 0, 0, 3'b010, 0, 0);
        cycle(1, 0, 0, 3'b010, 0, 0);
        for (int w = 0; w < 32; w++) cycle(0, 32'(w * 4), $urandom, 3'b010, 0, 1);
        cycle(0, 32'hFFC, $urandom, 3'b010, 0, 1);

        // Word store then byte load of the top lane.
        cycle(0, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, 1);
        cycle(0, 32'h13, 0, 3'b000, 1, 0);
        // Half store overlaid on a word.
        cycle(0, 32'h20, 32'hAAAA_AAAA, 3'b010, 0, 1);
        cycle(0, 32'h22, 32'h0000_1234, 3'b001, 0, 1);
        cycle(0, 32'h20, 0, 3'b010, 1, 0);
        // Unmapped store/load.
        cycle(0, 32'h0001_0000, 32'h5555_5555, 3'b010, 0, 1);
        cycle(0, 32'h0001_0000, 0, 3'b010, 1, 0);
        cycle(0, 32'h0, 0, 3'b010, 1, 0);
        // Counter and LED register.
        cycle(1, 0, 0, 3'b010, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 3'b010, 0, 0);
        cycle(0, MMIO_BASE, 0, 3'b010, 1, 0);
        cycle(0, MMIO_BASE + 32'h8, 32'h1A5, 3'b010, 0, 1);
        cycle(0, MMIO_BASE + 32'h8, 0, 3'b010, 1, 0);
        // Misaligned word loads: first fault sticks.
        cycle(0, 32'h06, 0, 3'b010, 1, 0);
        cycle(0, 32'h09, 0, 3'b010, 1, 0);
        cycle(0, MMIO_BASE + 32'hC, 0, 3'b010, 1, 0);
        // Reset with fault and LED set; RAM survives.
        cycle(1, 32'h10, 32'h0BAD_0BAD, 3'b010, 0, 1);
        cycle(0, 32'h10, 0, 3'b010, 1, 0);
        // Fault then status clear.
        cycle(0, 32'h21, 0, 3'b001, 1, 0);
        cycle(0, MMIO_BASE + 32'hC, 32'h1, 3'b010, 0, 1);
        cycle(0, 32'h23, 0, 3'b101, 0, 1);
        cycle(0, 32'h14, 32'hCAFE_F00D, 3'b010, 1, 1);
        cycle(0, 32'h14, 0, 3'b010, 1, 0);
        cycle(0, 32'h14, 0, 3'b011, 1, 0);

        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      a = 32'($urandom_range(0, 127));
            else if (r < 78) a = 32'hFFC + 32'($urandom_range(0, 3));
            else if (r < 86) a = 32'h1000 + 32'($urandom_range(0, 32'hFFF));
            else if (r < 94) a = MMIO_BASE + 32'($urandom_range(0, 15));
            else             a = $urandom | 32'h0001_0000;
            r = $urandom_range(0, 99);
            if (r < 90) begin
                case ($urandom_range(0, 4))
                    0: t = 3'b000;
                    1: t = 3'b001;
                    2: t = 3'b010;
                    3: t = 3'b100;
                    default: t = 3'b101;
                endcase
            end else begin
                t = 3'($urandom_range(0, 7));
            end
            cycle($urandom_range(0, 49) == 0, a, $urandom, t,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
        end

        cycle(0, 0, 0, 3'b010, 0, 0);
        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_0000, base of the 16-byte MMIO window.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port MEM_addr  input  32  byte address from CPU stage 3.
REQ-006 SHALL have port MEM_WR_out  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 SHALL have port MEM_type  input  3  transfer size: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; others illegal.
REQ-008 SHALL have port MEM_rd_en  input  1  load request this cycle.
REQ-009 SHALL have port MEM_wr_en  input  1  store request this cycle.
REQ-010 SHALL have port MEM_data  output  32  load data, right-aligned, upper bits zero, not sign-extended.
REQ-011 SHALL have port misalign_fault  output  1  sticky fault flag.
REQ-012 SHALL have port fault_addr  output  32  address of first fault since last clear.
REQ-013 SHALL have port led_out  output  8  MMIO LED register contents.

Function
REQ-014 SHALL return MEM_data combinationally in the same cycle as MEM_rd_en (zero-wait-state load).
REQ-015 SHALL commit stores at the rising edge ending the MEM_wr_en cycle; a same-cycle read sees the pre-store value.
REQ-016 SHALL index RAM by MEM_addr[log2(DEPTH_WORDS)+1:2] and place store bytes into lanes by MEM_addr[1:0] with per-byte write enables.
REQ-017 SHALL shift load data down by 8*MEM_addr[1:0] and mask to the transfer size.
REQ-018 SHALL treat half at odd address, word with MEM_addr[1:0]!=0, or illegal MEM_type as fault: no write, MEM_data=0.
REQ-019 SHALL set misalign_fault and capture fault_addr on a faulting access only when misalign_fault is clear; later faults don't overwrite.
REQ-020 SHALL treat addresses outside RAM and MMIO as unmapped: loads return 0, stores ignored, no fault.
REQ-021 SHALL, with MEM_rd_en and MEM_wr_en both high, perform the store only and drive MEM_data=0.
REQ-022 SHALL drive MEM_data=0 whenever MEM_rd_en is low.

Reset
REQ-023 SHALL, on Reset high at an edge, clear misalign_fault, fault_addr, led_out and the cycle counter to 0; RAM contents are not cleared.
REQ-024 SHALL ignore stores presented in a reset cycle; combinational loads remain functional.

Configuration
REQ-025 SHALL compile the MMIO window only when DMEM_MMIO_EN is defined; MMIO registers are word-access only (other sizes fault).
REQ-026 With DMEM_MMIO_EN: MMIO_BASE+0x0 counter[31:0] RO, +0x4 counter[63:32] RO, +0x8 led_out RW (bits [7:0], upper read 0), +0xC status RO bit0=misalign_fault, write-1 to bit0 clears fault.
REQ-027 With DMEM_MMIO_EN: 64-bit free-running counter increments every non-reset cycle, wraps to 0 after all-ones.
REQ-028 Without DMEM_MMIO_EN: MMIO window is unmapped per REQ-020, led_out tied 0, fault flag clearable only by Reset.
REQ-029 SHALL give a fault-clear write priority under a simultaneous new fault: impossible same cycle (one access/cycle), so clear takes effect and flag is 0 next cycle.

Structure
REQ-030 SHALL place MEM_type encodings, MMIO offsets and size/alignment check function in package dmem_pkg.
REQ-031 SHALL implement lane shifting/byte-enable generation in one sub-module dmem_lane_align; RAM array and MMIO in dmem_unit.

Verification
REQ-032 Word store 0xDEADBEEF @0x10, then byte load @0x13 -> MEM_data=0x000000DE same cycle.
REQ-033 Half store 0x1234 @0x22 over word 0xAAAAAAAA @0x20, word load @0x20 -> 0x1234AAAA.
REQ-034 Word load @0x06 -> MEM_data=0, misalign_fault=1 next cycle, fault_addr=0x6; second fault @0x09 leaves fault_addr=0x6.
REQ-035 DMEM_MMIO_EN: after Reset, 10 idle cycles, load MMIO_BASE+0x0 -> 10; store 0x1A5 to +0x8 -> led_out=0xA5.
REQ-036 Store to 0x0001_0000 (unmapped, DEPTH_WORDS=1024) -> no RAM change, load returns 0, misalign_fault stays 0.
REQ-037 Assert Reset mid-sequence with fault set and led_out=0xA5 -> both 0 next cycle; RAM word @0x10 still 0xDEADBEEF.
